i2c_tx_fifo: RTL
================

# i2c_tx_fifo

Synchronous first-word-fall-through FIFO that buffers transmit bytes from the MCU register interface before they reach the I2C data path. It sits directly upstream of the I2C data path, in the `i2c_core_clk_i` domain: the MCU pushes bytes in, and the data path pops one byte each time it finishes shifting one out. It also produces the FIFO fields of the MCU-visible status byte, including occupancy flags and sticky error flags.

## Interface
Parameters:
- DATA_SIZE, 8, width of one FIFO word
- DEPTH, 16, number of entries; must be a power of two and at least 4
- AW, $clog2(DEPTH), pointer width; derived, never overridden

Ports:
- i2c_core_clk_i  in  1  i2c core clock; all state updates on its rising edge
- reset_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush: empties the FIFO and clears sticky flags
- wr_en_i  in  1  push request (one word per cycle)
- data_i  in  DATA_SIZE  write data, sampled when wr_en_i=1
- rd_en_i  in  1  pop request from the data path (one word per cycle)
- data_o  out  DATA_SIZE  head word; valid whenever empty_o=0
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- count_o  out  AW+1  current occupancy, 0..DEPTH
- status_o  out  8  [0] empty, [1] full, [2] almost_full, [3] almost_empty, [4] overflow (sticky), [5] underflow (sticky), [7:6] = 0

## Operation
- Storage: DEPTH x DATA_SIZE register array, plus wr_ptr and rd_ptr (AW bits each, natural wrap at DEPTH) and count (AW+1 bits).
- Push is accepted when wr_en_i=1 and the FIFO is not full, or when wr_en_i=1 and the FIFO is full with rd_en_i=1 in the same cycle.
  - Accepted push: mem[wr_ptr] <= data_i, wr_ptr+1.
- Pop is accepted when rd_en_i=1 and count>0. Accepted pop: rd_ptr+1.
- count: +1 on push only, -1 on pop only, unchanged when both or neither happen.
- Rejected push (full and no pop): word dropped, overflow set. State is otherwise unchanged.
- Rejected pop (empty): underflow set. There is no bypass — a simultaneous push on empty is accepted, the pop is ignored, and underflow is set.
- almost_full: count >= DEPTH-2. almost_empty: count <= 1.
- Sticky flags: overflow and underflow hold until clear_i or reset.
- clear_i has priority over push and pop in the same cycle.
  - Next cycle: pointers=0, count=0, sticky flags=0.
  - The memory contents are not cleared.
- Pointers wrap silently at DEPTH-1 -> 0. Full and empty are decided from count, never from pointer equality.

## Timing
- Reset values: count_o=0, empty_o=1, full_o=0, status_o=8'h09, data_o=0.
  - Memory is not reset; data_o is forced to 0 while empty_o=1.
- data_o = mem[rd_ptr], combinational from registered state (FWFT).
- Write-to-read latency:
  - A word pushed at edge N appears on data_o, with empty_o=0, after edge N.
  - The data path may pop it in cycle N+1.
- A pop at edge N advances data_o to the next word after edge N.
- All flags and count_o are registered or decoded from registered count. None has a combinational path from wr_en_i or rd_en_i.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous); any in-flight push is lost.
- Deassertion of reset_i is assumed synchronised upstream.

## Structure
- Shared package i2c_pkg: localparams for the status_o bit indices (ST_EMPTY=0, ST_FULL=1, ST_AFULL=2, ST_AEMPTY=3, ST_OVF=4, ST_UDF=5).
  - The MCU register block and the receive FIFO reuse these indices.
- One sub-module, i2c_fifo_mem:
  - Parameterised DATA_SIZE/DEPTH register array with a write port and an asynchronous read port.
  - It also serves the future receive FIFO.
- Pointer, count and flag logic lives in i2c_tx_fifo.

## Test plan
- Reset, then 3 pushes (8'hA5, 8'h3C, 8'h7E) -> data_o=8'hA5 one cycle after the first push; count_o=3; status_o=8'h00.
- Fill with 16 pushes of 0..15, then push 8'hFF:
  - full_o=1, overflow set, status_o=8'h16.
  - 16 pops return 0..15 in order; afterwards status_o=8'h19.
- From empty, assert rd_en_i -> underflow set and count_o stays 0. Then clear_i -> status_o=8'h09.
- At full, simultaneous push 8'h55 and pop:
  - count_o stays 16, no overflow.
  - The popped word is the oldest; 8'h55 is returned last.
- Wrap: 10 pushes, 10 pops, 10 pushes (8'h20..8'h29) -> pops return 8'h20..8'h29 in order across the pointer wrap.
- Assert reset_i mid-burst with count_o=5 -> outputs go to reset values without waiting for a clock edge; the next push/pop sequence behaves as after power-up.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit positions of the MCU-visible FIFO status byte.
// Used by the transmit FIFO, the receive FIFO and the MCU register block.
// No logic; constants only.
package i2c_pkg;

    // status_o bit indices
    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_AFULL  = 2;
    localparam int ST_AEMPTY = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_UDF    = 5;

endpackage : i2c_pkg

// File: rtl/i2c_fifo_mem.sv
// FIFO storage array: DEPTH x DATA_SIZE registers, one write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from the array.
// Backpressure: none; the caller qualifies i_wr_en with its own full/flow logic.
//
// Ports:
//   i_clk      write clock
//   i_wr_en    write strobe for this cycle
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  word at i_rd_addr
module i2c_fifo_mem #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [DATA_SIZE-1:0] o_rd_data
);

    // Deliberately not reset: contents are qualified by the owner's count.
    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : i2c_fifo_mem

// File: rtl/i2c_tx_fifo.sv
// I2C transmit FIFO (first-word-fall-through) between the MCU register interface and the data path.
// Latency: a word pushed at edge N is on data_o after edge N; a pop at edge N advances data_o after edge N.
// Backpressure: push while full (without a same-cycle pop) is dropped and sets sticky overflow;
//               pop while empty is ignored and sets sticky underflow.
//
// Ports:
//   i2c_core_clk_i  core clock          reset_i   async active-high reset
//   clear_i         sync flush          wr_en_i / data_i   push request and data
//   rd_en_i         pop request         data_o    head word (0 while empty)
//   full_o, empty_o occupancy flags     count_o   occupancy 0..DEPTH
//   status_o        {2'b0, udf, ovf, aempty, afull, full, empty}
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 rd_en_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AW:0]          count_o,
    output logic [7:0]           status_o
);

    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AFULL = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_udf;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_SIZE-1:0] w_rd_data;

    // Full/empty come from the count only; the pointers alone are ambiguous when equal.
    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == '0);

    // A pop frees the slot in the same cycle, so a push at full is taken when paired with a pop.
    // No bypass: a push into an empty FIFO never satisfies a same-cycle pop.
    assign w_push = wr_en_i && (!w_full || rd_en_i);
    assign w_pop  = rd_en_i && !w_empty;

    i2c_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .i_clk     (i2c_core_clk_i),
        .i_wr_en   (w_push && !clear_i && !reset_i),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en_i && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (rd_en_i && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Stale array contents are hidden while empty.
    assign data_o  = w_empty ? '0 : w_rd_data;
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = r_count;

    always_comb begin
        status_o            = 8'h00;
        status_o[ST_EMPTY]  = w_empty;
        status_o[ST_FULL]   = w_full;
        status_o[ST_AFULL]  = (r_count >= CNT_AFULL);
        status_o[ST_AEMPTY] = (r_count <= CNT_ONE);
        status_o[ST_OVF]    = r_ovf;
        status_o[ST_UDF]    = r_udf;
    end

endmodule : i2c_tx_fifo
